sipo_framer: RTL and testbench
==============================

SIPO_FRAMER -- requirements
Module: sipo_framer

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the parallel word width in bits (N >= 2).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, a frame-start request, sampled only in IDLE.
REQ-005 The module SHALL have port bit_en, input, 1 bit, a strobe that qualifies sin for sampling.
REQ-006 The module SHALL have port sin, input, 1 bit, the serial data, LSB first.
REQ-007 The module SHALL have port word, output, N bits, the last completed parallel word, held between frames.
REQ-008 The module SHALL have port load, output, 1 bit, a one-cycle pulse marking a new word; it drives a downstream parallel-load register directly.
REQ-009 The module SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 The module SHALL have port par_err, output, 1 bit, the parity-error flag for the last completed word.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT, PARITY (present only with the macro) and DONE.
REQ-012 In IDLE, when start=1, the FSM SHALL go to SHIFT on the next edge with bit count 0; a bit_en in that same cycle SHALL NOT sample sin.
REQ-013 In SHIFT, each cycle with bit_en=1 SHALL shift sin into the MSB of an internal shift register (shift right) and increment the count; cycles with bit_en=0 SHALL hold the register and count.
REQ-014 When the Nth bit is sampled, the FSM SHALL go to PARITY (macro on) or DONE (macro off).
REQ-015 On entry to DONE, word SHALL update to the shift register, and load SHALL be 1 for exactly that one DONE cycle.
REQ-016 Latency: load SHALL assert in the cycle immediately after the edge that samples the last bit.
REQ-017 DONE SHALL always return to IDLE on the next edge; start asserted in DONE SHALL be ignored.
REQ-018 start asserted while busy=1 SHALL be ignored, and the in-progress frame SHALL NOT restart.
REQ-019 word SHALL change only on entry to DONE; load SHALL never assert in any other state.
REQ-020 The bit counter SHALL be $clog2(N+1) bits wide and SHALL clear on every exit from IDLE; it SHALL NOT wrap within a frame.

Reset
REQ-021 While reset=1 at an edge, the FSM SHALL go to IDLE and word, count, shift register and par_err SHALL clear to 0; load and busy SHALL read 0 in the following cycle.
REQ-022 A reset mid-frame SHALL discard the partial frame with no load pulse, and reset SHALL take priority over start and bit_en.

Configuration
REQ-023 When PARITY_EN is defined, each frame SHALL carry one even-parity bit after the N data bits, sampled in PARITY on bit_en.
REQ-024 When PARITY_EN is defined, par_err SHALL be set to (^data) XOR parity bit on entry to DONE and held until the next DONE; the word SHALL be delivered regardless.
REQ-025 When PARITY_EN is undefined, the PARITY state SHALL be absent, each frame SHALL be N bits, and par_err SHALL be constant 0.

Structure
REQ-026 Shared package sipo_pkg SHALL hold the state enum type, the default width constant (4), and the counter-width constant/function.
REQ-027 The design SHALL have exactly one sub-module, sipo_bit_counter: an enable/clear up-counter with a terminal-count output at a parameterised limit.

Verification
REQ-028 A bench SHALL cover this directed scenario: N=4, macro off; start, then bits 1,0,1,1 each with bit_en -> word=4'hD, load high for one cycle directly after the 4th sample, busy low the following cycle.
REQ-029 A bench SHALL cover this directed scenario: gaps of 0-3 cycles with bit_en=0 between bits 0,1,1,0 -> word=4'h6, no early load.
REQ-030 A bench SHALL cover this directed scenario: start pulsed again after 2 bits of frame 1,1,0,0 -> ignored, word=4'h3 after 4 bits.
REQ-031 A bench SHALL cover this directed scenario: reset asserted after 3 bits -> no load, word remains 0; next full frame 1,1,1,1 -> word=4'hF.
REQ-032 A bench SHALL cover this directed scenario: macro on; data 1,0,1,1 with parity 1 -> par_err=0; same data with parity 0 -> par_err=1, word=4'hD both times.
REQ-033 A bench SHALL cover this directed scenario: start and bit_en=1 with sin=1 in the same IDLE cycle -> that bit is not captured, and the next 4 strobed bits define the word.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out framer.
package sipo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_N = 4;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Enable/clear up-counter that saturates at LIMIT; tc flags the strobe that brings it to LIMIT.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int LIMIT = DEFAULT_N,
    parameter int W     = cnt_w(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] count;

    // Saturate rather than wrap so a stray strobe can never restart the count.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (count == LAST);

endmodule

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: start-triggered, bit_en-qualified LSB-first capture of N-bit words.
// Define PARITY_EN to append and check one even-parity bit per frame.
module sipo_framer
    import sipo_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_en,
    input  logic         sin,
    output logic [N-1:0] word,
    output logic         load,
    output logic         busy,
    output logic         par_err
);

    state_t       state;
    logic [N-1:0] sreg;
    logic [N-1:0] sreg_nxt;
    logic         take;
    logic         last;

    assign take     = (state == ST_SHIFT) && bit_en;
    assign sreg_nxt = {sin, sreg[N-1:1]};

    sipo_bit_counter #(.LIMIT(N)) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_IDLE),
        .en    (take),
        .tc    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            word  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (take) begin
                        sreg <= sreg_nxt;
                        if (last) begin
`ifdef PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_DONE;
                            word  <= sreg_nxt;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (bit_en) begin
                        state <= ST_DONE;
                        word  <= sreg;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PARITY_EN
    logic perr_q;

    // Even parity: XOR of data and parity bit is 1 only on an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if ((state == ST_PARITY) && bit_en) begin
            perr_q <= (^sreg) ^ sin;
        end
    end

    assign par_err = perr_q;
`else
    assign par_err = 1'b0;
`endif

    // Decoded straight from the state register so load is a clean one-cycle pulse.
    assign load = (state == ST_DONE);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sipo_framer.sv
// Directed bench for sipo_framer (N=4); parity scenarios build only with PARITY_EN.
`timescale 1ns/1ps
module tb_sipo_framer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       bit_en;
    logic       sin;
    logic [3:0] word;
    logic       load;
    logic       busy;
    logic       par_err;

    int checks;
    int errors;
    int load_cnt;
    int snap;

    sipo_framer #(.N(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bit_en  (bit_en),
        .sin     (sin),
        .word    (word),
        .load    (load),
        .busy    (busy),
        .par_err (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (load) load_cnt = load_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at a negedge with the FSM in SHIFT.
    task automatic do_start();
        @(negedge clk);
        start  = 1'b1;
        bit_en = 1'b0;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bit_en = 1'b0;
            @(negedge clk);
            chk("no_early_load", {31'd0, load}, 32'd0);
        end
        bit_en = 1'b1;
        sin    = b;
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    // Sends 4 data bits LSB first (plus parity when enabled) and checks the DONE cycle.
    task automatic frame(input string tag, input logic [3:0] data, input logic par,
                         input logic [3:0] exp_word, input logic exp_perr);
        snap = load_cnt;
        do_start();
        for (int i = 0; i < 4; i++) send_bit(data[i], 0);
`ifdef PARITY_EN
        chk({tag, "_par_wait_load"}, {31'd0, load}, 32'd0);
        chk({tag, "_par_wait_busy"}, {31'd0, busy}, 32'd1);
        send_bit(par, 0);
        chk({tag, "_perr"}, {31'd0, par_err}, {31'd0, exp_perr});
`else
        chk({tag, "_perr"}, {31'd0, par_err}, 32'd0);
        if (par !== 1'bx && exp_perr !== 1'bx) begin end
`endif
        chk({tag, "_load"}, {31'd0, load}, 32'd1);
        chk({tag, "_word"}, {28'd0, word}, {28'd0, exp_word});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_load_off"}, {31'd0, load}, 32'd0);
        chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        chk({tag, "_one_pulse"}, load_cnt - snap, 32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        load_cnt = 0;
        reset    = 1'b1;
        start    = 1'b0;
        bit_en   = 1'b0;
        sin      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_word", {28'd0, word}, 32'd0);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_perr", {31'd0, par_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Bits 1,0,1,1 -> 4'hD
        frame("basic", 4'b1101, 1'b1, 4'hD, 1'b0);

        // Bits 0,1,1,0 with gaps 0..3 -> 4'h6
        snap = load_cnt;
        do_start();
        send_bit(1'b0, 0);
        send_bit(1'b1, 1);
        send_bit(1'b1, 2);
        send_bit(1'b0, 3);
`ifdef PARITY_EN
        chk("gap_par_wait_load", {31'd0, load}, 32'd0);
        send_bit(1'b0, 0);
`endif
        chk("gap_load", {31'd0, load}, 32'd1);
        chk("gap_word", {28'd0, word}, 32'h6);
        @(negedge clk);
        chk("gap_one_pulse", load_cnt - snap, 32'd1);

        // Start pulsed mid-frame after bits 1,1 must be ignored -> 4'h3
        snap = load_cnt;
        do_start();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
`ifdef PARITY_EN
        send_bit(1'b0, 0);
`endif
        chk("restart_load", {31'd0, load}, 32'd1);
        chk("restart_word", {28'd0, word}, 32'h3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        chk("restart_one_pulse", load_cnt - snap, 32'd1);

        // Reset after 3 bits (with start/bit_en also high) discards the frame
        snap = load_cnt;
        do_start();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        reset  = 1'b1;
        start  = 1'b1;
        bit_en = 1'b1;
        sin    = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        bit_en = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_load", {31'd0, load}, 32'd0);
        chk("midrst_word", {28'd0, word}, 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_pulse", load_cnt - snap, 32'd0);
        chk("midrst_word_held", {28'd0, word}, 32'd0);
        frame("after_rst", 4'b1111, 1'b0, 4'hF, 1'b0);

        // Bit strobed in the same IDLE cycle as start is not captured
        snap = load_cnt;
        @(negedge clk);
        start  = 1'b1;
        bit_en = 1'b1;
        sin    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bit_en = 1'b0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("idle_bit_no_early", {31'd0, load}, 32'd0);
        send_bit(1'b0, 0);
`ifdef PARITY_EN
        send_bit(1'b1, 0);
`endif
        chk("idle_bit_load", {31'd0, load}, 32'd1);
        chk("idle_bit_word", {28'd0, word}, 32'h2);
        @(negedge clk);
        chk("idle_bit_one_pulse", load_cnt - snap, 32'd1);

`ifdef PARITY_EN
        frame("par_good", 4'b1101, 1'b1, 4'hD, 1'b0);
        frame("par_bad", 4'b1101, 1'b0, 4'hD, 1'b1);
        repeat (2) @(negedge clk);
        chk("par_err_held", {31'd0, par_err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
